// File: rtl/tlb_fill_arb.sv
// TLB fill arbiter: shares one page-table walker between the instruction and
// data TLBs, picks a victim entry for the owner, and emits one-hot write
// strobes or a fault pulse when the walk finishes.
module tlb_fill_arb #(
  parameter int TLB_ENTRIES = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ITLBMiss,
  input  logic                   DTLBMiss,
  input  logic [TLB_ENTRIES-1:0] ITLBValid,
  input  logic [TLB_ENTRIES-1:0] DTLBValid,
  input  logic                   TLBFlush,
  input  logic                   WalkDone,
  input  logic                   WalkFault,
  output logic                   WalkReq,
  output logic                   WalkSel,
  output logic [TLB_ENTRIES-1:0] ITLBWriteEnables,
  output logic [TLB_ENTRIES-1:0] DTLBWriteEnables,
  output logic                   IFault,
  output logic                   DFault,
  output logic                   Busy
);

  localparam int PTR_W = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;
  localparam logic [TLB_ENTRIES-1:0] ONE_HOT_BASE = {{(TLB_ENTRIES-1){1'b0}}, 1'b1};

  // Victim selection relies on power-of-two wrap of the round-robin pointers.
  if ((TLB_ENTRIES < 2) || ((TLB_ENTRIES & (TLB_ENTRIES - 1)) != 0)) begin : g_bad_entries
    $error("tlb_fill_arb: TLB_ENTRIES must be a power of two and at least 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WALK  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  state_e                   state_q;
  logic                     owner_q;       // 0 = ITLB, 1 = DTLB
  logic                     last_grant_q;  // owner of the most recent grant
  logic                     abort_q;       // flush seen during the current walk
  logic [PTR_W-1:0]         itlb_ptr_q;
  logic [PTR_W-1:0]         dtlb_ptr_q;
  logic [PTR_W-1:0]         victim_q;
  logic [TLB_ENTRIES-1:0]   we_q;
  logic                     ifault_q;
  logic                     dfault_q;

  logic                     grant_s;
  logic                     abort_s;
  logic [TLB_ENTRIES-1:0]   owner_valid_s;
  logic [PTR_W-1:0]         owner_ptr_s;
  logic [PTR_W-1:0]         victim_s;

  // Lowest-index invalid entry wins; a fully valid TLB falls back to its pointer.
  function automatic logic [PTR_W-1:0] pick_victim(input logic [TLB_ENTRIES-1:0] valid,
                                                   input logic [PTR_W-1:0]       rr_ptr);
    logic [PTR_W-1:0] idx;
    idx = rr_ptr;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      idx = valid[i] ? idx : PTR_W'(i);
    end
    return idx;
  endfunction

  // Arbitration: a lone requester wins; on a tie the side not granted last time wins.
  always_comb begin
    grant_s = 1'b0;
    if (ITLBMiss && DTLBMiss) begin
      grant_s = ~last_grant_q;
    end else begin
      grant_s = DTLBMiss;
    end
  end

  // Victim for the current walk owner, plus the effective abort (same-cycle flush counts).
  always_comb begin
    owner_valid_s = ITLBValid;
    owner_ptr_s   = itlb_ptr_q;
    if (owner_q) begin
      owner_valid_s = DTLBValid;
      owner_ptr_s   = dtlb_ptr_q;
    end else begin
      owner_valid_s = ITLBValid;
      owner_ptr_s   = itlb_ptr_q;
    end
    victim_s = pick_victim(owner_valid_s, owner_ptr_s);
    abort_s  = abort_q | TLBFlush;
  end

  // Fill FSM with registered strobes, fault pulses and round-robin pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b0;
      abort_q      <= 1'b0;
      itlb_ptr_q   <= '0;
      dtlb_ptr_q   <= '0;
      victim_q     <= '0;
      we_q         <= '0;
      ifault_q     <= 1'b0;
      dfault_q     <= 1'b0;
    end else begin
      we_q     <= '0;
      ifault_q <= 1'b0;
      dfault_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          abort_q <= 1'b0;
          if (ITLBMiss || DTLBMiss) begin
            owner_q      <= grant_s;
            last_grant_q <= grant_s;
            state_q      <= ST_WALK;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WALK: begin
          if (WalkDone) begin
            abort_q <= 1'b0;
            if (abort_s) begin
              state_q <= ST_IDLE;
            end else if (WalkFault) begin
              state_q  <= ST_IDLE;
              ifault_q <= ~owner_q;
              dfault_q <= owner_q;
            end else begin
              state_q  <= ST_WRITE;
              victim_q <= victim_s;
              we_q     <= ONE_HOT_BASE << victim_s;
            end
          end else begin
            state_q <= ST_WALK;
            abort_q <= abort_s;
          end
        end
        ST_WRITE: begin
          state_q <= ST_IDLE;
          // A flush in the write cycle kills the strobe, so the pointer stays put.
          if (!TLBFlush) begin
            if (owner_q) begin
              dtlb_ptr_q <= victim_q + PTR_W'(1);
            end else begin
              itlb_ptr_q <= victim_q + PTR_W'(1);
            end
          end else begin
            itlb_ptr_q <= itlb_ptr_q;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from registered state; reset and write-cycle flush mask them.
  assign WalkReq          = (state_q == ST_WALK) && !reset;
  assign WalkSel          = (state_q == ST_WALK) && owner_q && !reset;
  assign Busy             = (state_q != ST_IDLE) && !reset;
  assign ITLBWriteEnables = ((state_q == ST_WRITE) && !owner_q && !TLBFlush && !reset) ? we_q : '0;
  assign DTLBWriteEnables = ((state_q == ST_WRITE) &&  owner_q && !TLBFlush && !reset) ? we_q : '0;
  assign IFault           = ifault_q && !reset;
  assign DFault           = dfault_q && !reset;

endmodule

// File: tb/tb_tlb_fill_arb.sv
// Directed testbench for tlb_fill_arb with TLB_ENTRIES = 8.
module tb_tlb_fill_arb;

  logic       clk = 1'b0;
  logic       reset;
  logic       ITLBMiss, DTLBMiss;
  logic [7:0] ITLBValid, DTLBValid;
  logic       TLBFlush, WalkDone, WalkFault;
  logic       WalkReq, WalkSel, IFault, DFault, Busy;
  logic [7:0] ITLBWriteEnables, DTLBWriteEnables;

  int checks = 0;
  int errors = 0;

  tlb_fill_arb #(.TLB_ENTRIES(8)) dut (
    .clk(clk), .reset(reset),
    .ITLBMiss(ITLBMiss), .DTLBMiss(DTLBMiss),
    .ITLBValid(ITLBValid), .DTLBValid(DTLBValid),
    .TLBFlush(TLBFlush), .WalkDone(WalkDone), .WalkFault(WalkFault),
    .WalkReq(WalkReq), .WalkSel(WalkSel),
    .ITLBWriteEnables(ITLBWriteEnables), .DTLBWriteEnables(DTLBWriteEnables),
    .IFault(IFault), .DFault(DFault), .Busy(Busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a miss from IDLE, walk two cycles, pulse WalkDone; returns in the cycle after WalkDone.
  task automatic run_to_write(input logic is_d, input logic [7:0] valid);
    if (is_d) begin
      DTLBMiss = 1'b1; DTLBValid = valid;
    end else begin
      ITLBMiss = 1'b1; ITLBValid = valid;
    end
    step();
    ITLBMiss = 1'b0; DTLBMiss = 1'b0;
    step();
    WalkDone = 1'b1;
    step();
    WalkDone = 1'b0; WalkFault = 1'b0;
  endtask

  task automatic test_reset_and_tie();
    reset = 1'b1; ITLBMiss = 1'b1; DTLBMiss = 1'b1;
    step(); step();
    checks++; if ({WalkReq, WalkSel, Busy, IFault, DFault} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b required 00000", {WalkReq, WalkSel, Busy, IFault, DFault}); end
    checks++; if ({ITLBWriteEnables, DTLBWriteEnables} !== 16'h0000) begin errors++; $display("FAIL reset_strobes: got %h required 0000", {ITLBWriteEnables, DTLBWriteEnables}); end
    reset = 1'b0; #1;
    checks++; if ({WalkReq, WalkSel, Busy} !== 3'b000) begin errors++; $display("FAIL post_reset_ctrl: got %b required 000", {WalkReq, WalkSel, Busy}); end
    step();
    checks++; if (WalkReq !== 1'b1) begin errors++; $display("FAIL tie_walkreq: got %b required 1", WalkReq); end
    checks++; if (WalkSel !== 1'b1) begin errors++; $display("FAIL tie_walksel_d: got %b required 1", WalkSel); end
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL tie_busy: got %b required 1", Busy); end
    DTLBValid = 8'hFF; DTLBMiss = 1'b0;
    step();
    checks++; if (WalkSel !== 1'b1) begin errors++; $display("FAIL walksel_hold: got %b required 1", WalkSel); end
    WalkDone = 1'b1;
    step();
    WalkDone = 1'b0;
    checks++; if (DTLBWriteEnables !== 8'b00000001) begin errors++; $display("FAIL tie_d_write: got %b required 00000001", DTLBWriteEnables); end
    checks++; if (ITLBWriteEnables !== 8'b0) begin errors++; $display("FAIL tie_i_quiet: got %b required 00000000", ITLBWriteEnables); end
    checks++; if ({WalkReq, Busy} !== 2'b01) begin errors++; $display("FAIL write_state: got %b required 01", {WalkReq, Busy}); end
    step();
    checks++; if ({DTLBWriteEnables, Busy} !== 9'b0) begin errors++; $display("FAIL write_one_cycle: got %b required 0", {DTLBWriteEnables, Busy}); end
    step();
    checks++; if ({WalkReq, WalkSel} !== 2'b10) begin errors++; $display("FAIL second_grant_i: got %b required 10", {WalkReq, WalkSel}); end
    ITLBMiss = 1'b0; ITLBValid = 8'hFF; WalkDone = 1'b1;
    step();
    WalkDone = 1'b0;
    checks++; if (ITLBWriteEnables !== 8'b00000001) begin errors++; $display("FAIL tie_i_write: got %b required 00000001", ITLBWriteEnables); end
    step();
  endtask

  task automatic test_first_invalid();
    run_to_write(1'b0, 8'b11110111);
    checks++; if (ITLBWriteEnables !== 8'b00001000) begin errors++; $display("FAIL first_invalid: got %b required 00001000", ITLBWriteEnables); end
    checks++; if (DTLBWriteEnables !== 8'b0) begin errors++; $display("FAIL first_invalid_d: got %b required 00000000", DTLBWriteEnables); end
    step();
    checks++; if ({ITLBWriteEnables, Busy} !== 9'b0) begin errors++; $display("FAIL first_invalid_end: got %b required 0", {ITLBWriteEnables, Busy}); end
    run_to_write(1'b0, 8'hFF);
    checks++; if (ITLBWriteEnables !== 8'b00010000) begin errors++; $display("FAIL iptr_after_invalid: got %b required 00010000", ITLBWriteEnables); end
    step();
  endtask

  task automatic test_wrap();
    run_to_write(1'b1, 8'b10111111);
    checks++; if (DTLBWriteEnables !== 8'b01000000) begin errors++; $display("FAIL d_entry6: got %b required 01000000", DTLBWriteEnables); end
    step();
    run_to_write(1'b1, 8'hFF);
    checks++; if (DTLBWriteEnables !== 8'b10000000) begin errors++; $display("FAIL d_ptr7: got %b required 10000000", DTLBWriteEnables); end
    step();
    run_to_write(1'b1, 8'hFF);
    checks++; if (DTLBWriteEnables !== 8'b00000001) begin errors++; $display("FAIL d_wrap: got %b required 00000001", DTLBWriteEnables); end
    step();
  endtask

  task automatic test_abort();
    ITLBMiss = 1'b1; ITLBValid = 8'hFF;
    step();
    ITLBMiss = 1'b0;
    step();
    TLBFlush = 1'b1;
    step();
    TLBFlush = 1'b0;
    checks++; if (WalkReq !== 1'b1) begin errors++; $display("FAIL abort_walk_continues: got %b required 1", WalkReq); end
    step();
    WalkDone = 1'b1;
    step();
    WalkDone = 1'b0;
    checks++; if ({ITLBWriteEnables, IFault, Busy, WalkReq} !== 11'b0) begin errors++; $display("FAIL abort_done: got %b required 0", {ITLBWriteEnables, IFault, Busy, WalkReq}); end
    step();
    checks++; if (ITLBWriteEnables !== 8'b0) begin errors++; $display("FAIL abort_no_late_write: got %b required 00000000", ITLBWriteEnables); end
    // Flush arriving together with WalkDone also aborts.
    DTLBMiss = 1'b1; DTLBValid = 8'hFF;
    step();
    DTLBMiss = 1'b0; WalkDone = 1'b1; TLBFlush = 1'b1;
    step();
    WalkDone = 1'b0; TLBFlush = 1'b0;
    checks++; if ({DTLBWriteEnables, DFault, Busy} !== 10'b0) begin errors++; $display("FAIL abort_same_cycle: got %b required 0", {DTLBWriteEnables, DFault, Busy}); end
    run_to_write(1'b0, 8'hFF);
    checks++; if (ITLBWriteEnables !== 8'b00100000) begin errors++; $display("FAIL abort_ptr_kept: got %b required 00100000", ITLBWriteEnables); end
    step();
  endtask

  task automatic test_fault();
    WalkFault = 1'b1;
    run_to_write(1'b1, 8'hFF);
    checks++; if ({DFault, IFault} !== 2'b10) begin errors++; $display("FAIL dfault_pulse: got %b required 10", {DFault, IFault}); end
    checks++; if ({DTLBWriteEnables, Busy} !== 9'b0) begin errors++; $display("FAIL fault_no_write: got %b required 0", {DTLBWriteEnables, Busy}); end
    step();
    checks++; if (DFault !== 1'b0) begin errors++; $display("FAIL dfault_one_cycle: got %b required 0", DFault); end
    run_to_write(1'b1, 8'hFF);
    checks++; if (DTLBWriteEnables !== 8'b00000010) begin errors++; $display("FAIL fault_ptr_kept: got %b required 00000010", DTLBWriteEnables); end
    step();
  endtask

  task automatic test_flush_write();
    run_to_write(1'b0, 8'hFF);
    TLBFlush = 1'b1; #1;
    checks++; if ({ITLBWriteEnables, DTLBWriteEnables} !== 16'h0000) begin errors++; $display("FAIL flush_write_masked: got %h required 0000", {ITLBWriteEnables, DTLBWriteEnables}); end
    step();
    TLBFlush = 1'b0;
    run_to_write(1'b0, 8'hFF);
    checks++; if (ITLBWriteEnables !== 8'b01000000) begin errors++; $display("FAIL flush_write_ptr: got %b required 01000000", ITLBWriteEnables); end
    step();
  endtask

  task automatic test_idle_ignores();
    TLBFlush = 1'b1; WalkDone = 1'b1;
    step(); step();
    checks++; if ({Busy, WalkReq, ITLBWriteEnables, DTLBWriteEnables} !== 18'b0) begin errors++; $display("FAIL idle_ignores: got %b required 0", {Busy, WalkReq, ITLBWriteEnables, DTLBWriteEnables}); end
    TLBFlush = 1'b0; WalkDone = 1'b0;
    run_to_write(1'b0, 8'hFF);
    checks++; if (ITLBWriteEnables !== 8'b10000000) begin errors++; $display("FAIL i_ptr7: got %b required 10000000", ITLBWriteEnables); end
    step();
    run_to_write(1'b0, 8'hFF);
    checks++; if (ITLBWriteEnables !== 8'b00000001) begin errors++; $display("FAIL i_wrap: got %b required 00000001", ITLBWriteEnables); end
    step();
  endtask

  task automatic test_reset_mid();
    DTLBMiss = 1'b1; DTLBValid = 8'hFF;
    step();
    DTLBMiss = 1'b0; WalkDone = 1'b1; reset = 1'b1;
    step();
    WalkDone = 1'b0;
    checks++; if ({DTLBWriteEnables, DFault, Busy, WalkReq} !== 11'b0) begin errors++; $display("FAIL reset_at_done: got %b required 0", {DTLBWriteEnables, DFault, Busy, WalkReq}); end
    reset = 1'b0; #1;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_at_done_busy: got %b required 0", Busy); end
    run_to_write(1'b1, 8'hFF);
    checks++; if (DTLBWriteEnables !== 8'b00000001) begin errors++; $display("FAIL reset_dptr0: got %b required 00000001", DTLBWriteEnables); end
    step();
    run_to_write(1'b0, 8'hFF);
    checks++; if (ITLBWriteEnables !== 8'b00000001) begin errors++; $display("FAIL reset_iptr0: got %b required 00000001", ITLBWriteEnables); end
    step();
    run_to_write(1'b0, 8'hFF);
    reset = 1'b1; #1;
    checks++; if (ITLBWriteEnables !== 8'b0) begin errors++; $display("FAIL reset_mid_write: got %b required 00000000", ITLBWriteEnables); end
    step();
    reset = 1'b0;
    run_to_write(1'b0, 8'hFF);
    checks++; if (ITLBWriteEnables !== 8'b00000001) begin errors++; $display("FAIL reset_mid_write_ptr: got %b required 00000001", ITLBWriteEnables); end
    step();
  endtask

  initial begin
    reset = 1'b1; ITLBMiss = 1'b0; DTLBMiss = 1'b0;
    ITLBValid = 8'hFF; DTLBValid = 8'hFF;
    TLBFlush = 1'b0; WalkDone = 1'b0; WalkFault = 1'b0;
    test_reset_and_tie();
    test_first_invalid();
    test_wrap();
    test_abort();
    test_fault();
    test_flush_write();
    test_idle_ignores();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlb_fill_arb.md
TLB_FILL_ARB -- requirements
Module: tlbfillarb

Interface
REQ-001 Parameter TLB_ENTRIES, default 8, meaning entries per TLB; the block SHALL require a power of two, at least 2.
REQ-002 clk  input  1  clock; single clock domain.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ITLBMiss, DTLBMiss  input  1 each  instruction/data TLB miss request, held by requester.
REQ-005 ITLBValid, DTLBValid  input  TLB_ENTRIES each  per-entry valid bits of each TLB.
REQ-006 TLBFlush  input  1  SFENCE.VMA/satp flush.
REQ-007 WalkDone, WalkFault  input  1 each  shared page-table walker completion pulse; fault qualifier.
REQ-008 WalkReq  output  1  walk request to shared walker.
REQ-009 WalkSel  output  1  walk owner: 0 = ITLB, 1 = DTLB.
REQ-010 ITLBWriteEnables, DTLBWriteEnables  output  TLB_ENTRIES each  one-hot entry write strobes.
REQ-011 IFault, DFault  output  1 each  one-cycle walk-fault pulse to owner.
REQ-012 Busy  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, WALK, WRITE; all outputs registered or decoded from registered state only.
REQ-014 IDLE: if any miss present, SHALL latch owner and go to WALK next cycle; no miss -> stay IDLE.
REQ-015 Arbitration SHALL be: single requester wins; both pending -> grant opposite of LastGrant; LastGrant updates on every grant.
REQ-016 WalkReq SHALL be high throughout WALK and low in all other states; WalkSel SHALL hold the latched owner for the whole walk.
REQ-017 Miss deassertion during WALK or WRITE SHALL be ignored; misses sampled only in IDLE.
REQ-018 WALK + WalkDone & ~WalkFault & ~Abort -> WRITE; WalkDone & WalkFault -> IDLE with owner's fault pulse next cycle; WalkDone & Abort -> IDLE, no write, no fault.
REQ-019 Abort flag SHALL set on TLBFlush in WALK and clear on leaving WALK; TLBFlush in same cycle as WalkDone SHALL count as abort.
REQ-020 WRITE SHALL last exactly one cycle: owner's WriteEnables one-hot at victim index, other TLB's strobes zero, then IDLE.
REQ-021 TLBFlush during WRITE SHALL force all write strobes to zero that cycle; victim pointer unchanged.
REQ-022 Victim SHALL be lowest-index entry with Valid=0 if any; else owner's round-robin pointer.
REQ-023 Separate pointers per TLB; after a non-suppressed write, owner's pointer SHALL become (victim+1) mod TLB_ENTRIES, wrapping from TLB_ENTRIES-1 to 0.
REQ-024 Latency: miss seen in IDLE cycle n -> WalkReq at n+1; WalkDone at cycle m -> write strobe (or fault pulse) at m+1; earliest next grant at m+2.
REQ-025 TLBFlush in IDLE SHALL have no effect on FSM or pointers.
REQ-026 WalkDone outside WALK SHALL be ignored.

Reset
REQ-027 On reset: state IDLE, LastGrant = ITLB (so DTLB wins first tie), both pointers 0, Abort 0.
REQ-028 During reset cycle and the cycle after: WalkReq, WalkSel, all write strobes, IFault, DFault, Busy SHALL be 0.
REQ-029 Reset asserted mid-WALK or mid-WRITE SHALL abandon the transaction with no write strobe or fault emitted.

Verification
REQ-030 TLB_ENTRIES=8, both misses same cycle after reset -> WalkSel=1 first; after DTLB completes, ITLB granted with WalkSel=0.
REQ-031 ITLBValid=8'b11110111, DTLBMiss=0, ITLBMiss=1, WalkDone clean -> ITLBWriteEnables=8'b00001000 one cycle, ITLB pointer unchanged semantics: becomes 4.
REQ-032 DTLBValid all ones, pointer 7, clean walk -> DTLBWriteEnables=8'b10000000, pointer wraps to 0; next fill writes 8'b00000001.
REQ-033 TLBFlush pulse two cycles into WALK, WalkDone later -> no write strobe, no fault, IDLE, Busy low next cycle.
REQ-034 WalkDone with WalkFault for DTLB -> DFault pulse exactly one cycle, DTLBWriteEnables stay 0, pointer unchanged.
REQ-035 Reset asserted the cycle WalkDone arrives -> no strobe, pointers 0, Busy 0.
